// File: rtl/input_demux_reg.sv
// input_demux_reg: rebuilds packed 32-bit buffer words from replicated
// lane words on the fusion-array lane bus. It strips the 2-bit replicas,
// flags any replica disagreement (sticky), gathers 1, 2 or 4 beats per
// word, and holds each finished word in a registered output slot.
//
// Handshake: a beat moves on a rising edge where in_valid && in_ready; a
// word moves on a rising edge where out_valid && out_ready. in_ready never
// looks at in_valid. It drops only when the pending beat would complete a
// word while the output slot is full and not being drained this cycle.
module input_demux_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  weight_bitwidth,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] sorted_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] buffer,
  output logic        dup_error
);

  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] buffer_q, buffer_d;
  logic        out_valid_q, out_valid_d;
  logic        dup_error_q, dup_error_d;

  // Lane extraction and replica comparison for both replicated modes.
  logic [7:0][1:0] lane4;
  logic [7:0]      dup4_bits;
  logic [3:0][1:0] lane8;
  logic [3:0]      dup8_bits;

  genvar k;
  for (k = 0; k < 8; k++) begin : g_lane4
    assign lane4[k]     = sorted_data[4*k +: 2];
    assign dup4_bits[k] = (sorted_data[4*k+2 +: 2] != sorted_data[4*k +: 2]);
  end

  for (k = 0; k < 4; k++) begin : g_lane8
    assign lane8[k]     = sorted_data[8*k +: 2];
    assign dup8_bits[k] = (sorted_data[8*k+2 +: 2] != sorted_data[8*k +: 2]) ||
                          (sorted_data[8*k+4 +: 2] != sorted_data[8*k +: 2]) ||
                          (sorted_data[8*k+6 +: 2] != sorted_data[8*k +: 2]);
  end

  logic        dup01, dup1x;
  logic [15:0] slice16;
  logic [7:0]  slice8;

  // In 2-beat mode the sorter interleaves lanes 1/2 and 5/6; undo that here.
  assign dup01   = |dup4_bits;
  assign dup1x   = |dup8_bits;
  assign slice16 = {lane4[7], lane4[5], lane4[6], lane4[4],
                    lane4[3], lane4[1], lane4[2], lane4[0]};
  assign slice8  = {lane8[3], lane8[2], lane8[1], lane8[0]};

  // The mode for the beat on the bus: live input on beat 0, latched after.
  logic [1:0]  eff_mode;
  logic        final_beat;
  logic        beat_dup;
  logic [31:0] merged;
  logic        accept;

  assign eff_mode = (beat_cnt_q == 2'd0) ? weight_bitwidth : mode_q;

  // Merge the current beat's slice into the accumulator and classify the beat.
  always_comb begin
    merged     = acc_q;
    beat_dup   = 1'b0;
    final_beat = 1'b0;
    if (eff_mode == 2'b00) begin
      merged     = sorted_data;
      final_beat = 1'b1;
    end else if (eff_mode == 2'b01) begin
      beat_dup   = dup01;
      final_beat = (beat_cnt_q == 2'd1);
      if (beat_cnt_q[0]) merged[31:16] = slice16;
      else               merged[15:0]  = slice16;
    end else begin
      beat_dup   = dup1x;
      final_beat = (beat_cnt_q == 2'd3);
      case (beat_cnt_q)
        2'd0:    merged[7:0]   = slice8;
        2'd1:    merged[15:8]  = slice8;
        2'd2:    merged[23:16] = slice8;
        default: merged[31:24] = slice8;
      endcase
    end
  end

  assign in_ready = !(final_beat && out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state: beat counting, mode latch, word completion, output slot.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    buffer_d    = buffer_q;
    out_valid_d = out_valid_q;
    dup_error_d = dup_error_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (beat_cnt_q == 2'd0) mode_d = weight_bitwidth;
      if (beat_dup)           dup_error_d = 1'b1;
      if (final_beat) begin
        buffer_d    = merged;
        out_valid_d = 1'b1;
        beat_cnt_d  = 2'd0;
        acc_d       = 32'h0;
      end else begin
        acc_d      = merged;
        beat_cnt_d = beat_cnt_q + 2'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q  <= 2'd0;
      mode_q      <= 2'b00;
      acc_q       <= 32'h0;
      buffer_q    <= 32'h0;
      out_valid_q <= 1'b0;
      dup_error_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      buffer_q    <= buffer_d;
      out_valid_q <= out_valid_d;
      dup_error_q <= dup_error_d;
    end
  end

  assign out_valid = out_valid_q;
  assign buffer    = buffer_q;
  assign dup_error = dup_error_q;

endmodule

// File: tb/tb_input_demux_reg.sv
// Directed bench for input_demux_reg: hand-computed words, an expected-word
// queue consumed on every output handshake, and single-line summary.
module tb_input_demux_reg;

  logic        clk;
  logic        reset;
  logic [1:0]  weight_bitwidth;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sorted_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] buffer;
  logic        dup_error;

  int errors = 0;
  int checks = 0;
  int word_cnt = 0;
  int snap;
  logic [31:0] exp_q[$];

  input_demux_reg dut (
    .clk            (clk),
    .reset          (reset),
    .weight_bitwidth(weight_bitwidth),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .sorted_data    (sorted_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .buffer         (buffer),
    .dup_error      (dup_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: offer one beat, wait (bounded) for acceptance
  task automatic send_beat(input logic [1:0] mode, input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    in_valid        = 1'b1;
    weight_bitwidth = mode;
    sorted_data     = data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) step();
    else    check("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // scoreboard: every consumed word must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      word_cnt++;
      if (exp_q.size() == 0) check("unexpected_word", buffer, 32'hxxxxxxxx);
      else                   check("word", buffer, exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; weight_bitwidth = 2'b00;
    sorted_data = 32'h0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_buffer", buffer, 32'h0);
    check("rst_dup", {31'd0, dup_error}, 32'd0);
    step();

    // mode 00: one beat per word, one cycle latency
    exp_q.push_back(32'hDEADBEEF);
    send_beat(2'b00, 32'hDEADBEEF);
    @(negedge clk);
    check("m00_valid", {31'd0, out_valid}, 32'd1);
    check("m00_buffer", buffer, 32'hDEADBEEF);
    check("m00_dup", {31'd0, dup_error}, 32'd0);
    step();

    // mode 1x: four back-to-back beats, exactly one word
    snap = word_cnt;
    exp_q.push_back(32'h000000A5);
    send_beat(2'b10, 32'hAAAA5555);
    send_beat(2'b10, 32'h0);
    send_beat(2'b10, 32'h0);
    send_beat(2'b10, 32'h0);
    @(negedge clk);
    check("m1x_buffer", buffer, 32'h000000A5);
    step(); step(); step();
    check("m1x_pulses", word_cnt - snap, 32'd1);

    // mode 01: halves, lane 1/2 and 5/6 interleave
    exp_q.push_back(32'h0000FFFF);
    send_beat(2'b01, 32'hFFFFFFFF);
    send_beat(2'b01, 32'h0);
    @(negedge clk);
    check("m01_ones", buffer, 32'h0000FFFF);
    step();
    exp_q.push_back(32'h00000030);
    send_beat(2'b01, 32'h000000F0);
    send_beat(2'b01, 32'h0);
    @(negedge clk);
    check("m01_lane1", buffer, 32'h00000030);
    step();
    exp_q.push_back(32'h0000000C);
    send_beat(2'b01, 32'h00000F00);
    send_beat(2'b01, 32'h0);
    @(negedge clk);
    check("m01_lane2", buffer, 32'h0000000C);
    step();
    exp_q.push_back(32'h00300000);
    send_beat(2'b01, 32'h0);
    send_beat(2'b01, 32'h000000F0);
    @(negedge clk);
    check("m01_upper", buffer, 32'h00300000);
    check("m01_no_dup", {31'd0, dup_error}, 32'd0);
    step();

    // replica mismatch: sticky error, data from the low copy
    exp_q.push_back(32'h000000A4);
    send_beat(2'b10, 32'hAAAA5554);
    send_beat(2'b10, 32'h0);
    send_beat(2'b10, 32'h0);
    send_beat(2'b10, 32'h0);
    @(negedge clk);
    check("dup_buffer", buffer, 32'h000000A4);
    check("dup_set", {31'd0, dup_error}, 32'd1);
    step();
    exp_q.push_back(32'h12345678);
    send_beat(2'b00, 32'h12345678);
    @(negedge clk);
    check("dup_sticky", {31'd0, dup_error}, 32'd1);
    step();

    // backpressure: final beat stalls until the held word drains
    out_ready = 1'b0;
    exp_q.push_back(32'h11112222);
    exp_q.push_back(32'h00C00003);
    send_beat(2'b00, 32'h11112222);
    send_beat(2'b01, 32'h0000000F);
    in_valid = 1'b1; weight_bitwidth = 2'b01; sorted_data = 32'h0000F000;
    @(negedge clk);
    check("bp_stall", {31'd0, in_ready}, 32'd0);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_buffer", buffer, 32'h11112222);
    step();
    @(negedge clk);
    check("bp_stall2", {31'd0, in_ready}, 32'd0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid_kept", {31'd0, out_valid}, 32'd1);
    check("bp_new_word", buffer, 32'h00C00003);
    step();

    // mode change after beat 0 is ignored for that word
    exp_q.push_back(32'h0C000030);
    send_beat(2'b01, 32'h000000F0);
    send_beat(2'b00, 32'h0F000000);
    @(negedge clk);
    check("mode_latch", buffer, 32'h0C000030);
    step();

    // reset mid-word discards the partial word and the error flag
    send_beat(2'b10, 32'hFFFFFFFF);
    send_beat(2'b10, 32'hFFFFFFFF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_buffer", buffer, 32'h0);
    step();
    exp_q.push_back(32'hAA5500D8);
    send_beat(2'b10, 32'hFF55AA00);
    send_beat(2'b10, 32'h00000000);
    send_beat(2'b10, 32'h55555555);
    send_beat(2'b10, 32'hAAAAAAAA);
    @(negedge clk);
    check("rst_fresh_word", buffer, 32'hAA5500D8);
    check("rst_fresh_dup", {31'd0, dup_error}, 32'd0);
    step(); step(); step();

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
